// File: rtl/phase_pulse_trigger_if.sv
// Sample stream into the pulse trigger and the event stream out of it.
interface phase_pulse_trigger_if #(
  parameter int CHAN_W = 8,
  parameter int TIME_W = 36
);
  logic                in_valid;
  logic [CHAN_W-1:0]   in_chan;
  logic signed [15:0]  in_phase;
  logic [TIME_W-1:0]   in_time;

  logic                evt_valid;
  logic [CHAN_W-1:0]   evt_chan;
  logic signed [15:0]  evt_peak;
  logic [TIME_W-1:0]   evt_time;

  modport master (
    output in_valid, in_chan, in_phase, in_time,
    input  evt_valid, evt_chan, evt_peak, evt_time
  );

  modport slave (
    input  in_valid, in_chan, in_phase, in_time,
    output evt_valid, evt_chan, evt_peak, evt_time
  );
endinterface

// File: rtl/phase_pulse_trigger.sv
// Per-channel negative phase pulse detector over a time-multiplexed sample stream,
// with one state-RAM entry per channel and a two-stage read/modify/write pipeline.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | armed, waiting for a sample below threshold
// ST_TRACK | inside a pulse, min holds the lowest phase seen so far
// ST_HOLD  | post-pulse holdoff, count samples left to ignore minus one
// ST_BAD   | illegal encoding, behaves as ST_IDLE
module phase_pulse_trigger #(
  parameter int N_CHAN = 256,
  parameter int CHAN_W = 8,
  parameter int TIME_W = 36
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic [31:0]          threshold_reg,
  phase_pulse_trigger_if.slave io,
  output logic                 init_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_HOLD  = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  typedef struct packed {
    state_t      state;
    logic [15:0] min;
    logic [7:0]  count;
  } entry_t;

  localparam entry_t ENTRY_IDLE = '0;

  entry_t ram [N_CHAN];

  logic [24:0]        thr_q;
  logic               thr_en;
  logic [7:0]         thr_hold;
  logic signed [15:0] thr_val;
  logic               unused_reserved;

  logic               s1_valid;
  logic [CHAN_W-1:0]  s1_chan;
  logic signed [15:0] s1_phase;
  logic [TIME_W-1:0]  s1_time;
  entry_t             s1_entry;
  logic signed [15:0] s1_min;

  logic [CHAN_W-1:0]  clr_idx;
  logic               clr_done;

  entry_t             nxt;
  logic               fire;
  logic               wr_en;
  logic [CHAN_W-1:0]  wr_addr;
  entry_t             wr_data;

  assign unused_reserved = &threshold_reg[30:24];
  assign thr_en   = thr_q[24];
  assign thr_hold = thr_q[23:16];
  assign thr_val  = $signed(thr_q[15:0]);
  assign s1_min   = $signed(s1_entry.min);

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      thr_q        <= '0;
      s1_valid     <= 1'b0;
      clr_idx      <= '0;
      clr_done     <= 1'b0;
      init_done    <= 1'b0;
      io.evt_valid <= 1'b0;
      io.evt_chan  <= '0;
      io.evt_peak  <= '0;
      io.evt_time  <= '0;
    end else begin
      thr_q    <= {threshold_reg[31], threshold_reg[23:0]};
      s1_valid <= io.in_valid & init_done;
      if (!clr_done) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == CHAN_W'(N_CHAN - 1)) clr_done <= 1'b1;
      end
      init_done    <= clr_done;
      io.evt_valid <= fire;
      if (fire) begin
        io.evt_chan <= s1_chan;
        io.evt_peak <= s1_min;
        io.evt_time <= s1_time;
      end
    end
  end

  // Pipeline data and RAM need no reset; the clear sweep owns RAM initialisation.
  always_ff @(posedge user_clk) begin
    s1_chan  <= io.in_chan;
    s1_phase <= io.in_phase;
    s1_time  <= io.in_time;
    s1_entry <= ram[io.in_chan];
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  always_comb begin
    nxt  = s1_entry;
    fire = 1'b0;
    if (!thr_en) begin
      nxt = ENTRY_IDLE;
    end else begin
      case (s1_entry.state)
        ST_TRACK: begin
          if (s1_phase < s1_min) begin
            nxt.min = s1_phase;
          end else begin
            fire = s1_valid;
            if (thr_hold == 8'd0) begin
              nxt = ENTRY_IDLE;
            end else begin
              nxt.state = ST_HOLD;
              nxt.count = thr_hold - 8'd1;
            end
          end
        end
        ST_HOLD: begin
          if (s1_entry.count == 8'd0) nxt = ENTRY_IDLE;
          else                        nxt.count = s1_entry.count - 8'd1;
        end
        default: begin
          if (s1_phase < thr_val) begin
            nxt.state = ST_TRACK;
            nxt.min   = s1_phase;
            nxt.count = 8'd0;
          end else begin
            nxt = ENTRY_IDLE;
          end
        end
      endcase
    end

    wr_en   = 1'b1;
    wr_addr = clr_idx;
    wr_data = ENTRY_IDLE;
    if (clr_done) begin
      wr_en   = s1_valid;
      wr_addr = s1_chan;
      wr_data = nxt;
    end
  end

endmodule

// File: tb/tb_phase_pulse_trigger.sv
// Randomised and directed stimulus for phase_pulse_trigger, checked against a
// per-channel behavioural model with an expected-event queue.
module tb_phase_pulse_trigger;
  localparam int N  = 8;
  localparam int CW = 3;
  localparam int TW = 36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] thr_word = 32'h0;
  logic        init_done;

  phase_pulse_trigger_if #(.CHAN_W(CW), .TIME_W(TW)) bus ();

  phase_pulse_trigger #(.N_CHAN(N), .CHAN_W(CW), .TIME_W(TW)) dut (
    .user_clk      (clk),
    .user_rst      (rst),
    .threshold_reg (thr_word),
    .io            (bus.slave),
    .init_done     (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    int     chan;
    int     peak;
    longint tm;
  } evt_t;

  evt_t        q[$];
  int          trk[N];
  int          mn[N];
  int          skp[N];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          n_evt    = 0;
  int          ev_mark  = 0;
  bit          ready    = 1'b0;
  bit          mon_exp;
  logic [35:0] t_next;

  task automatic check(string tag, longint obs, longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Holdoff modelled as a number of samples still to be skipped.
  task automatic model_step(int c, int ph, longint tm);
    bit en   = thr_word[31];
    int thr  = int'($signed(thr_word[15:0]));
    int hold = int'(thr_word[23:16]);
    evt_t e;
    if (!en) begin
      trk[c] = 0;
      skp[c] = 0;
      return;
    end
    if (skp[c] > 0) begin
      skp[c]--;
      return;
    end
    if (trk[c] != 0) begin
      if (ph < mn[c]) begin
        mn[c] = ph;
      end else begin
        e.due = cyc + 2; e.chan = c; e.peak = mn[c]; e.tm = tm;
        q.push_back(e);
        trk[c] = 0;
        skp[c] = hold;
      end
    end else if (ph < thr) begin
      trk[c] = 1;
      mn[c]  = ph;
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    mon_exp = (q.size() > 0) && (q[0].due == cyc);
    check("evt_valid", longint'(bus.evt_valid), longint'(mon_exp));
    if (bus.evt_valid) n_evt++;
    if (mon_exp) begin
      if (bus.evt_valid) begin
        check("evt_chan", longint'(bus.evt_chan), q[0].chan);
        check("evt_peak", $signed(bus.evt_peak), q[0].peak);
        check("evt_time", longint'(bus.evt_time), q[0].tm);
      end
      void'(q.pop_front());
    end
  end

  task automatic drive(bit v, int c, int ph);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_chan  = CW'(c);
    bus.in_phase = 16'(ph);
    bus.in_time  = t_next;
    if (v && ready) model_step(c, ph, longint'(t_next));
    t_next += 36'(1 + $urandom_range(0, 5));
  endtask

  task automatic send(int c, int ph);
    drive(1'b1, c, ph);
    drive(1'b0, 0, 0);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic set_thr(logic [31:0] w);
    @(negedge clk);
    bus.in_valid = 1'b0;
    thr_word     = w;
  endtask

  task automatic expect_events(string tag, int exp);
    idle(3);
    check(tag, n_evt - ev_mark, exp);
    ev_mark = n_evt;
  endtask

  // Sweep takes N+1 cycles after release; in_valid pulses meanwhile must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    ready        = 1'b0;
    q.delete();
    for (int i = 0; i < N; i++) begin
      trk[i] = 0; mn[i] = 0; skp[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("rst_evt_chan", longint'(bus.evt_chan), 0);
    check("rst_evt_peak", longint'(bus.evt_peak), 0);
    check("rst_evt_time", longint'(bus.evt_time), 0);
    check("rst_init_done", longint'(init_done), 0);
    rst = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_chan  = CW'($urandom_range(0, N - 1));
      bus.in_phase = -16'sd3000;
      @(posedge clk);
      #1;
      check("init_done_timing", longint'(init_done), longint'(k == N + 1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    ready        = 1'b1;
    ev_mark      = n_evt;
  endtask

  initial begin
    bit prev_v;
    int prev_c;
    int c;
    int thr;
    t_next       = {4'($urandom), 32'($urandom)};
    bus.in_valid = 1'b0;
    bus.in_chan  = '0;
    bus.in_phase = '0;
    bus.in_time  = '0;

    do_reset();
    expect_events("sweep_no_events", 0);

    set_thr(32'h8005FC18);
    send(3, -500); send(3, -1200); send(3, -1800); send(3, -1500);
    expect_events("basic_pulse", 1);

    repeat (5) send(3, -2000);
    expect_events("holdoff_silent", 0);
    send(3, -2000); send(3, -2000);
    expect_events("equal_terminates", 1);

    send(4, -1000);
    expect_events("at_threshold", 0);
    send(4, -1001); send(4, -999);
    expect_events("just_below", 1);

    drive(1'b1, 0, -1100); drive(1'b1, 1, -1300); drive(1'b1, 0, -1400);
    drive(1'b1, 1, -1200); drive(1'b1, 0, -1400);
    expect_events("interleaved", 2);

    set_thr(32'h8000FC18);
    send(2, -1200); send(2, -1100); send(2, -1300); send(2, -1200);
    expect_events("holdoff_zero", 2);

    set_thr(32'h8005FC18);
    send(5, -1500);
    set_thr(32'h0005FC18);
    send(5, -1600);
    set_thr(32'h8005FC18);
    send(5, -900); send(5, -1100);
    expect_events("disable_discard", 0);
    send(5, -1050);
    expect_events("rearm_after_enable", 1);

    send(6, -1500);
    drive(1'b1, 6, -1400);
    do_reset();
    send(6, -900);
    expect_events("reset_drops_pulse", 0);

    prev_v = 1'b0;
    prev_c = 0;
    for (int blk = 0; blk < 5; blk++) begin
      thr = -int'($urandom_range(0, 2000));
      set_thr({1'($urandom_range(0, 9) != 0), 7'($urandom), 8'($urandom_range(0, 6)), 16'(thr)});
      prev_v = 1'b0;
      for (int i = 0; i < 400; i++) begin
        bit v = ($urandom_range(0, 9) < 7);
        do c = int'($urandom_range(0, N - 1)); while (prev_v && v && c == prev_c);
        drive(v, c, int'($urandom_range(0, 3500)) - 3000);
        prev_v = v;
        prev_c = c;
      end
      if (blk == 2) begin
        do_reset();
        prev_v = 1'b0;
      end
    end
    idle(4);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/phase_pulse_trigger.md
Name: phase_pulse_trigger

Overview:
- Per-channel pulse trigger sitting directly downstream of the capture threshold software register, in the user_clk domain of the wavelength capture path.
- Consumes the 32-bit threshold/control word and a time-multiplexed stream of per-resonator phase samples.
- Detects negative-going phase pulses per channel, tracks each pulse minimum, emits one event per pulse (channel, peak, time), then applies a per-channel holdoff.
- Events feed the photon capture/packetiser stage.

Parameters:
- N_CHAN, 256, number of time-multiplexed channels (2..1024)
- CHAN_W, 8, channel index width, clog2(N_CHAN)
- TIME_W, 36, timestamp width

Ports:
- user_clk  in  1  sole clock
- user_rst  in  1  synchronous, active-high reset
- threshold_reg  in  32  control word from the threshold register:
  - [15:0] signed threshold
  - [23:16] holdoff, in samples of the same channel
  - [30:24] reserved, ignored
  - [31] enable
- in_valid  in  1  in_chan/in_phase/in_time valid this cycle
- in_chan  in  CHAN_W  channel index of the sample
- in_phase  in  16  signed phase sample
- in_time  in  TIME_W  timestamp of the sample
- evt_valid  out  1  one-cycle event strobe
- evt_chan  out  CHAN_W  channel of the event
- evt_peak  out  16  signed minimum phase of the pulse
- evt_time  out  TIME_W  in_time of the sample that ended tracking
- init_done  out  1  high once the state-RAM clear sweep has finished

Behaviour:
- Reset:
  - evt_valid=0, evt_chan=0, evt_peak=0, evt_time=0, init_done=0.
  - A clear counter then writes IDLE (min=0, count=0) to entries 0..N_CHAN-1, one per cycle.
  - init_done rises the cycle after entry N_CHAN-1 is written, i.e. N_CHAN+1 cycles after user_rst deasserts.
  - in_valid is ignored while init_done=0.
  - user_rst asserted mid-operation aborts everything, drops in-flight events and restarts the sweep.
- State RAM:
  - One 26-bit entry per channel: state[1:0], min[15:0], count[7:0].
  - Stage 1 registers the sample and reads the channel entry.
  - Stage 2 computes next state, writes back and registers the event outputs.
- Latency: evt_valid is asserted exactly 2 cycles after the in_valid cycle of the terminating sample.
- Input constraint: the same channel must not recur within 2 consecutive valid cycles; upstream round-robin over N_CHAN>=2 channels guarantees this. No bypass is built.
- Threshold word:
  - Sampled into a register each cycle; changes apply 1 cycle later.
  - All comparisons are signed 16-bit.
- Per-channel state machine (evaluated only on valid samples of that channel):
  - IDLE: if in_phase < thr (strict), go to TRACK with min=in_phase; otherwise stay in IDLE.
  - TRACK, in_phase < min: min=in_phase, stay in TRACK.
  - TRACK, in_phase >= min (including equal values):
    - emit event with evt_peak=min, evt_time=in_time;
    - if holdoff=0, go to IDLE;
    - otherwise go to HOLDOFF with count=holdoff-1.
  - HOLDOFF: if count=0, go to IDLE; otherwise count=count-1. The sample is never compared against thr in this state.
  - Net effect: exactly holdoff samples after the terminating sample are ignored.
  - Encoding 2'b11 is illegal and is treated as IDLE.
- enable=0:
  - Every visited entry is written as IDLE; no events are emitted.
  - Pulses in TRACK are discarded without an event.
- A terminating sample never re-arms in the same cycle, even if it is below thr.
- evt_* outputs hold their last value when evt_valid=0.

Test Plan:
- Reset, then N_CHAN=4 -> init_done low for exactly 5 cycles after user_rst falls; in_valid pulses during the sweep produce no events and no state changes.
- threshold_reg=0x8005FC18 (thr=-1000, holdoff=5, enable=1); chan 3 samples -500, -1200, -1800, -1500 -> one evt_valid 2 cycles after the -1500 sample, evt_chan=3, evt_peak=-1800, evt_time = time of the -1500 sample.
- Same setup; next 5 chan-3 samples all -2000 -> no events (holdoff); 6th sample -2000 -> enters TRACK; 7th sample -2000 -> event with peak -2000 (equal value terminates).
- Sample exactly -1000 -> no trigger; sample -1001 then -999 -> event with peak -1001.
- Chans 0 and 1 interleaved, both pulsing -> independent events with correct chan and peak per channel; holdoff=0 with chan 2 at -1200, -1100, -1300, -1200 -> two events, peaks -1200 and -1300.
- Chan 5 in TRACK at -1500, enable cleared, next chan-5 sample -1600, enable set, next chan-5 samples -900, -1100, -1050 -> no event until -1050, then peak -1100. Separately, user_rst asserted mid-TRACK -> no event is ever emitted for that pulse.
